// File: rtl/char_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output character ROM between text requesters.
// Owner tags ride a pipeline aligned with ROM data so each code returns to its requester.
module char_rom_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 7,
    parameter int ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*ADDR_W-1:0] addr_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [ADDR_W-1:0]      rom_addr_o,
    input  logic [DATA_W-1:0]      rom_data_i,
    output logic [NREQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_data_o,
    output logic                   busy_o
);
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]              ptr_q, ptr_d;
    logic [NREQ-1:0]               gnt_q, gnt_d;
    logic [ADDR_W-1:0]             rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]              vld_q, vld_d;
    logic [ROM_LAT:0][PTR_W-1:0]   own_q, own_d;
    logic [NREQ-1:0]               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]             rsp_data_q, rsp_data_d;

    logic                          win_found;
    logic [PTR_W-1:0]              win_idx;
    logic [PTR_W:0]                cand;

    // Search upward from ptr, wrapping modulo NREQ; first asserted request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NREQ))
                cand = cand - (PTR_W+1)'(NREQ);
            if (!win_found && req_i[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        gnt_d      = '0;
        rom_addr_d = rom_addr_q;
        if (win_found) begin
            ptr_d      = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
            gnt_d      = NREQ'(1) << win_idx;
            rom_addr_d = addr_i[win_idx*ADDR_W +: ADDR_W];
        end
    end

    // Stage 0 holds the tag of the address currently on rom_addr_o; stage ROM_LAT
    // lines up with the ROM data produced for it.
    always_comb begin
        vld_d       = {vld_q[ROM_LAT-1:0], win_found};
        own_d       = {own_q[ROM_LAT-1:0], win_idx};
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (vld_q[ROM_LAT]) begin
            rsp_valid_d = NREQ'(1) << own_q[ROM_LAT];
            rsp_data_d  = rom_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            rom_addr_q  <= '0;
            vld_q       <= '0;
            own_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rom_addr_q  <= rom_addr_d;
            vld_q       <= vld_d;
            own_q       <= own_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rom_addr_o  = rom_addr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = |vld_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Bench for char_rom_arbiter: two instances (ROM_LAT=1 and 3) share stimulus and a
// cycle-history reference model; directed literal checks plus randomized traffic.
module tb_char_rom_arbiter;
    localparam int NREQ = 3, AW = 8, DW = 7, MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NREQ-1:0]    req_i = '0;
    logic [NREQ*AW-1:0] addr_i = '0;

    logic [NREQ-1:0] g1, g3, rv1, rv3;
    logic [AW-1:0]   a1, a3;
    logic [DW-1:0]   rd1, rd3, r1, r3a, r3b, r3c;
    logic            b1, b3;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    char_rom_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .gnt_o(g1),
        .rom_addr_o(a1), .rom_data_i(r1), .rsp_valid_o(rv1), .rsp_data_o(rd1), .busy_o(b1));
    char_rom_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .gnt_o(g3),
        .rom_addr_o(a3), .rom_data_i(r3c), .rsp_valid_o(rv3), .rsp_data_o(rd3), .busy_o(b3));

    // Text ROM: "START GAME" at 0..9, arbitrary filler elsewhere.
    function automatic logic [6:0] rom_f(input logic [7:0] a);
        logic [7:0] t;
        case (a)
            8'd0: t = 8'h53; 8'd1: t = 8'h54; 8'd2: t = 8'h41; 8'd3: t = 8'h52;
            8'd4: t = 8'h54; 8'd5: t = 8'h20; 8'd6: t = 8'h47; 8'd7: t = 8'h41;
            8'd8: t = 8'h4D; 8'd9: t = 8'h45;
            default: t = a * 8'd7 + 8'd3;
        endcase
        return t[6:0];
    endfunction

    always @(posedge clk) begin
        r1  <= rom_f(a1);
        r3a <= rom_f(a3);
        r3b <= r3a;
        r3c <= r3b;
    end

    // Reference model: history of grants per cycle; outputs derived from it.
    int cyc = 0, base = 1, ptr = 0;
    bit          g_vld [MAXC];
    int          g_idx [MAXC];
    logic [7:0]  g_addr[MAXC];
    logic [2:0]  exp_gnt = '0, exp_rv1 = '0, exp_rv3 = '0;
    logic [7:0]  exp_addr = '0;
    logic [6:0]  exp_rd1 = '0, exp_rd3 = '0;
    logic        exp_b1 = 1'b0, exp_b3 = 1'b0;

    task automatic derive(input int L, output logic [2:0] rv, inout logic [6:0] rd, output logic b);
        int s;
        s  = cyc - L - 1;
        rv = '0;
        if (s >= base && g_vld[s % MAXC]) begin
            rv = 3'(1 << g_idx[s % MAXC]);
            rd = rom_f(g_addr[s % MAXC]);
        end
        b = 1'b0;
        for (int j = cyc - L; j <= cyc; j++)
            if (j >= base && g_vld[j % MAXC]) b = 1'b1;
    endtask

    initial forever begin
        int win;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            base = cyc + 1; ptr = 0;
            exp_gnt = '0; exp_addr = '0; exp_rv1 = '0; exp_rv3 = '0;
            exp_rd1 = '0; exp_rd3 = '0; exp_b1 = 1'b0; exp_b3 = 1'b0;
        end else begin
            cyc++;
            win = -1;
            for (int i = 0; i < NREQ; i++)
                if (win < 0 && req_i[(ptr + i) % NREQ]) win = (ptr + i) % NREQ;
            g_vld[cyc % MAXC] = (win >= 0);
            exp_gnt = '0;
            if (win >= 0) begin
                g_idx[cyc % MAXC]  = win;
                g_addr[cyc % MAXC] = addr_i[win*AW +: AW];
                exp_gnt  = 3'(1 << win);
                exp_addr = addr_i[win*AW +: AW];
                ptr      = (win + 1) % NREQ;
            end
            derive(1, exp_rv1, exp_rd1, exp_b1);
            derive(3, exp_rv3, exp_rd3, exp_b3);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("gnt1", 32'(g1), 32'(exp_gnt));   chk("gnt3", 32'(g3), 32'(exp_gnt));
        chk("addr1", 32'(a1), 32'(exp_addr)); chk("addr3", 32'(a3), 32'(exp_addr));
        chk("rv1", 32'(rv1), 32'(exp_rv1));   chk("rd1", 32'(rd1), 32'(exp_rd1));
        chk("rv3", 32'(rv3), 32'(exp_rv3));   chk("rd3", 32'(rd3), 32'(exp_rd3));
        chk("busy1", 32'(b1), 32'(exp_b1));   chk("busy3", 32'(b3), 32'(exp_b3));
    end

    bit         rq[NREQ];
    logic [7:0] ra[NREQ];
    int rrg[6] = '{1, 2, 4, 1, 2, 4};
    int rrd[3] = '{'h53, 'h54, 'h41};

    initial begin
        int na, nr;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 32'(g1), 0); chk("rst_rv", 32'(rv1), 0);
            chk("rst_rd", 32'(rd1), 0); chk("rst_busy", 32'(b3), 0);
        end
        rst_n = 1'b1;

        // Round robin with all three requesting
        @(negedge clk);
        req_i = 3'b111; addr_i = {8'd2, 8'd1, 8'd0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(g1), 32'(rrg[i]));
            if (i >= 2) begin
                chk("rr_rsp", 32'(rv1), 32'(rrg[i-2]));
                chk("rr_dat", 32'(rd1), 32'(rrd[(i-2) % 3]));
            end
            if (i == 5) req_i = '0;
        end
        repeat (6) @(negedge clk);

        // Single request, addr 2 -> 'A'
        req_i = 3'b001; addr_i = {8'd0, 8'd0, 8'd2};
        @(negedge clk);
        chk("single_gnt", 32'(g1), 1); chk("single_addr", 32'(a1), 2);
        req_i = '0;
        repeat (2) @(negedge clk);
        chk("single_rv1", 32'(rv1), 1); chk("single_rd1", 32'(rd1), 'h41);
        repeat (2) @(negedge clk);
        chk("single_rv3", 32'(rv3), 1); chk("single_rd3", 32'(rd3), 'h41);
        repeat (6) @(negedge clk);

        // Latency 3: req 2 addr 6 -> 'G'
        req_i = 3'b100; addr_i = {8'd6, 8'd0, 8'd0};
        @(negedge clk);
        chk("lat_gnt3", 32'(g3), 4);
        req_i = '0;
        repeat (4) @(negedge clk);
        chk("lat_rv3", 32'(rv3), 4); chk("lat_rd3", 32'(rd3), 'h47);
        repeat (6) @(negedge clk);

        // Streaming from req 1
        req_i = 3'b010; addr_i = '0;
        na = 0; nr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (g1 == 3'b010) begin
                chk("stream_busy", 32'(b1), 1);
                na++;
                if (na == 10) req_i = '0; else addr_i[AW +: AW] = 8'(na);
            end
            if (rv1 == 3'b010) begin
                chk("stream_chr", 32'(rd1), 32'(rom_f(8'(nr))));
                nr++;
            end
        end
        chk("stream_cnt", nr, 10);

        // Move ptr back to 0, then contention where req 2 drops
        req_i = 3'b100;
        @(negedge clk);
        req_i = '0;
        repeat (4) @(negedge clk);
        req_i = 3'b101; addr_i = {8'd8, 8'd0, 8'd7};
        @(negedge clk);
        chk("drop_gnt0", 32'(g1), 1);
        req_i = '0;
        repeat (6) begin
            @(negedge clk);
            chk("drop_gnt2", 32'(g1[2]), 0);
            chk("drop_rv2a", 32'(rv1[2]), 0); chk("drop_rv2b", 32'(rv3[2]), 0);
        end

        // Reset mid-flight with two lookups outstanding
        req_i = 3'b001; addr_i = {8'd0, 8'd0, 8'd5};
        @(negedge clk);
        chk("mf_gnt0", 32'(g1), 1);
        req_i = 3'b010; addr_i = {8'd0, 8'd3, 8'd0};
        @(posedge clk); #1;
        chk("mf_gnt1", 32'(g1), 2);
        req_i = '0;
        rst_n = 1'b0;
        #1;
        chk("mf_gnt", 32'(g1), 0);  chk("mf_addr", 32'(a1), 0);
        chk("mf_rv", 32'(rv1), 0);  chk("mf_rd", 32'(rd1), 0);
        chk("mf_busy", 32'(b1), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_i = 3'b110; addr_i = {8'd2, 8'd1, 8'd0};
        @(negedge clk);
        chk("mf_ptr", 32'(g1), 2);
        req_i = '0;
        chk("mf_norsp1", 32'(rv1), 0);
        @(negedge clk);
        chk("mf_norsp1b", 32'(rv1), 0); chk("mf_norsp3", 32'(rv3), 0);
        repeat (8) @(negedge clk);

        // Randomized protocol-following traffic
        for (int k = 0; k < NREQ; k++) begin rq[k] = 1'b0; ra[k] = '0; end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) begin
                if (exp_gnt[k]) begin
                    if ($urandom_range(3) != 0) ra[k] = 8'($urandom_range(255));
                    else rq[k] = 1'b0;
                end else if (!rq[k]) begin
                    if ($urandom_range(2) == 0) begin rq[k] = 1'b1; ra[k] = 8'($urandom_range(255)); end
                end else if ($urandom_range(15) == 0) rq[k] = 1'b0;
                req_i[k] = rq[k];
                addr_i[k*AW +: AW] = ra[k];
            end
        end
        req_i = '0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
